// File: rtl/int_sched.sv
// Interrupt/trap entry and return sequencer: arbitrates program trap vs external irqs,
// stalls and drains the pipe, captures SRR0, redirects to the vector, tracks handler residency.
// Latency: request edge -> redirect two cycles later when the pipe is already empty; pipe_stall holds fetch/issue.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   irq_req/irq_mask/ee : level-sensitive external requests, per-line enable, global enable
//   trap_hit/trap_pc    : program interrupt from the trap unit and its faulting address
//   pipe_pc/pipe_empty  : next-to-commit address and drain status from the pipeline
//   rfi                 : return-from-interrupt commit pulse
//   pipe_stall, redirect/redirect_pc, srr0, cause, irq_ack, en_int, in_handler : outputs
module int_sched #(
    parameter int unsigned          N_SRC     = 4,
    parameter int unsigned          PC_W      = 30,
    parameter logic [PC_W-1:0]      VEC_BASE  = 'h40,
    parameter int unsigned          VEC_SHIFT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    irq_req,
    input  logic [N_SRC-1:0]    irq_mask,
    input  logic                ee,
    input  logic                trap_hit,
    input  logic [PC_W-1:0]     trap_pc,
    input  logic [PC_W-1:0]     pipe_pc,
    input  logic                pipe_empty,
    input  logic                rfi,
    output logic                pipe_stall,
    output logic                redirect,
    output logic [PC_W-1:0]     redirect_pc,
    output logic [PC_W-1:0]     srr0,
    output logic [3:0]          cause,
    output logic [N_SRC-1:0]    irq_ack,
    output logic                en_int,
    output logic                in_handler
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_ENTER   = 3'd2,
        S_HANDLER = 3'd3,
        S_RETURN  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cause_q, cause_d;
    logic [PC_W-1:0]    srr0_q,  srr0_d;

    logic [N_SRC-1:0]   pend;
    logic [3:0]         pend_cause;
    logic [PC_W-1:0]    vec_pc;

    // Enabled, globally-gated requests; only consulted while idle.
    assign pend = irq_req & irq_mask & {N_SRC{ee}};

    // Lowest-numbered pending line wins: scanning downward lets the lowest
    // index overwrite any higher one found earlier in the loop.
    always_comb begin
        pend_cause = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pend_cause = 4'(i + 1);
            end
        end
    end

    // Vector address wraps modulo 2^PC_W by construction of the PC_W-wide sum.
    assign vec_pc = VEC_BASE + (PC_W'(cause_q) << VEC_SHIFT);

    // Next-state and captured-context logic.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        srr0_d  = srr0_q;
        unique case (state_q)
            S_IDLE: begin
                // The program interrupt has priority; a level irq that loses
                // is simply retaken once the handler returns.
                if (trap_hit) begin
                    cause_d = 4'd0;
                    srr0_d  = trap_pc;
                    state_d = S_DRAIN;
                end else if (|pend) begin
                    cause_d = pend_cause;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Cause is already latched, so a request dropping here does
                // not cancel entry. For irqs the return point is the first
                // uncommitted instruction once the pipe has drained.
                if (pipe_empty) begin
                    if (cause_q != 4'd0) begin
                        srr0_d = pipe_pc;
                    end
                    state_d = S_ENTER;
                end
            end
            S_ENTER: begin
                state_d = S_HANDLER;
            end
            S_HANDLER: begin
                // No nesting: new requests and traps are not looked at here.
                if (rfi) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cause_q <= 4'd0;
            srr0_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            srr0_q  <= srr0_d;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // relative to the clock and redirect_pc is stable for the whole redirect cycle.
    always_comb begin
        pipe_stall  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        en_int      = 1'b0;
        in_handler  = 1'b0;
        irq_ack     = '0;
        unique case (state_q)
            S_IDLE: begin
                en_int = 1'b1;
            end
            S_DRAIN: begin
                pipe_stall = 1'b1;
            end
            S_ENTER: begin
                pipe_stall  = 1'b1;
                redirect    = 1'b1;
                redirect_pc = vec_pc;
                // Cause 0 is the program interrupt, which has no line to ack.
                for (int i = 0; i < N_SRC; i++) begin
                    irq_ack[i] = (cause_q == 4'(i + 1));
                end
            end
            S_HANDLER: begin
                in_handler = 1'b1;
            end
            S_RETURN: begin
                pipe_stall  = 1'b1;
                redirect    = 1'b1;
                redirect_pc = srr0_q;
            end
            default: begin
                en_int = 1'b0;
            end
        endcase
    end

    assign srr0  = srr0_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_int_sched.sv
module tb_int_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic        ee;
    logic        trap_hit;
    logic [29:0] trap_pc;
    logic [29:0] pipe_pc;
    logic        pipe_empty;
    logic        rfi;
    logic        pipe_stall;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic [29:0] srr0;
    logic [3:0]  cause;
    logic [3:0]  irq_ack;
    logic        en_int;
    logic        in_handler;

    int n_chk  = 0;
    int n_fail = 0;

    int_sched dut (
        .clk         (clk),
        .reset       (reset),
        .irq_req     (irq_req),
        .irq_mask    (irq_mask),
        .ee          (ee),
        .trap_hit    (trap_hit),
        .trap_pc     (trap_pc),
        .pipe_pc     (pipe_pc),
        .pipe_empty  (pipe_empty),
        .rfi         (rfi),
        .pipe_stall  (pipe_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .srr0        (srr0),
        .cause       (cause),
        .irq_ack     (irq_ack),
        .en_int      (en_int),
        .in_handler  (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs applied before the edge, outputs expected after it.
    typedef struct packed {
        logic [3:0]  req;
        logic        trap;
        logic [29:0] tpc;
        logic [29:0] ppc;
        logic        empty;
        logic        rfi;
        logic        e_stall;
        logic        e_redir;
        logic [29:0] e_rpc;
        logic [29:0] e_srr0;
        logic [3:0]  e_cause;
        logic [3:0]  e_ack;
        logic        e_en;
        logic        e_inh;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_stall, input logic e_redir,
                           input logic [29:0] e_rpc, input logic [29:0] e_srr0,
                           input logic [3:0] e_cause, input logic [3:0] e_ack,
                           input logic e_en, input logic e_inh);
        chk({tag, ".pipe_stall"},  64'(pipe_stall),  64'(e_stall));
        chk({tag, ".redirect"},    64'(redirect),    64'(e_redir));
        chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e_rpc));
        chk({tag, ".srr0"},        64'(srr0),        64'(e_srr0));
        chk({tag, ".cause"},       64'(cause),       64'(e_cause));
        chk({tag, ".irq_ack"},     64'(irq_ack),     64'(e_ack));
        chk({tag, ".en_int"},      64'(en_int),      64'(e_en));
        chk({tag, ".in_handler"},  64'(in_handler),  64'(e_inh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase of the current interrupt episode.
    localparam int M_FREE = 0, M_WAIT = 1, M_VECT = 2, M_RES = 3, M_BACK = 4;
    int          m_ph;
    int          m_cause;
    logic [29:0] m_srr0;

    function automatic int lowest_line(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph    = M_FREE;
        m_cause = 0;
        m_srr0  = '0;
    endtask

    // Advance the model by one clock edge using the inputs now on the pins.
    task automatic model_edge();
        int ln;
        ln = lowest_line(ee ? (irq_req & irq_mask) : 4'h0);
        if (m_ph == M_FREE) begin
            if (trap_hit) begin
                m_cause = 0; m_srr0 = trap_pc; m_ph = M_WAIT;
            end else if (ln >= 0) begin
                m_cause = ln + 1; m_ph = M_WAIT;
            end
        end else if (m_ph == M_WAIT) begin
            if (pipe_empty) begin
                if (m_cause > 0) m_srr0 = pipe_pc;
                m_ph = M_VECT;
            end
        end else if (m_ph == M_VECT) begin
            m_ph = M_RES;
        end else if (m_ph == M_RES) begin
            if (rfi) m_ph = M_BACK;
        end else begin
            m_ph = M_FREE;
        end
    endtask

    task automatic model_check(input string tag);
        logic [29:0] e_rpc;
        logic [3:0]  e_ack;
        e_rpc = '0;
        e_ack = '0;
        if (m_ph == M_VECT) begin
            e_rpc = 30'((32'h40 + 32'(m_cause) * 8) % (1 << 30));
            if (m_cause > 0) e_ack = 4'(1 << (m_cause - 1));
        end
        if (m_ph == M_BACK) e_rpc = m_srr0;
        chk_all(tag,
                (m_ph == M_WAIT) || (m_ph == M_VECT) || (m_ph == M_BACK),
                (m_ph == M_VECT) || (m_ph == M_BACK),
                e_rpc, m_srr0, 4'(m_cause), e_ack,
                m_ph == M_FREE, m_ph == M_RES);
    endtask

    task automatic quiet_inputs();
        irq_req    = 4'h0;
        trap_hit   = 1'b0;
        rfi        = 1'b0;
        pipe_empty = 1'b1;
    endtask

    initial begin
        //                req    trp   tpc       ppc       emp   rfi   stl   rdr   rpc       srr0      cau   ack      en    inh
        tbl[0]  = '{4'b0100, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,   30'h0,   4'd3, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b1, 1'b1, 30'h58,  30'h100, 4'd3, 4'b0100, 1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h100, 4'd3, 4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 1'b0, 30'h0,   30'h100, 1'b1, 1'b1, 1'b1, 1'b1, 30'h100, 30'h100, 4'd3, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h100, 4'd3, 4'b0000, 1'b1, 1'b0};
        tbl[5]  = '{4'b0001, 1'b1, 30'h200, 30'h100, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,   30'h200, 4'd0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b0001, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b1, 1'b1, 30'h40,  30'h200, 4'd0, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'b0001, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h200, 4'd0, 4'b0000, 1'b0, 1'b1};
        tbl[8]  = '{4'b0001, 1'b0, 30'h0,   30'h100, 1'b1, 1'b1, 1'b1, 1'b1, 30'h200, 30'h200, 4'd0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b0001, 1'b0, 30'h0,   30'h100, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h200, 4'd0, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{4'b0001, 1'b0, 30'h0,   30'h300, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,   30'h200, 4'd1, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{4'b0001, 1'b0, 30'h0,   30'h300, 1'b1, 1'b0, 1'b1, 1'b1, 30'h48,  30'h300, 4'd1, 4'b0001, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 30'h0,   30'h300, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h300, 4'd1, 4'b0000, 1'b0, 1'b1};
        tbl[13] = '{4'b0000, 1'b0, 30'h0,   30'h300, 1'b1, 1'b1, 1'b1, 1'b1, 30'h300, 30'h300, 4'd1, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 30'h0,   30'h300, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0,   30'h300, 4'd1, 4'b0000, 1'b1, 1'b0};

        // Reset state
        reset    = 1'b0;
        irq_mask = 4'hF;
        ee       = 1'b1;
        trap_pc  = '0;
        pipe_pc  = '0;
        quiet_inputs();
        #12;
        chk_all("reset", 1'b0, 1'b0, 30'h0, 30'h0, 4'd0, 4'h0, 1'b1, 1'b0);
        reset = 1'b1;

        // Irq entry/return, then trap-beats-irq and irq retaken after return
        for (int i = 0; i < 15; i++) begin
            irq_req    = tbl[i].req;
            trap_hit   = tbl[i].trap;
            trap_pc    = tbl[i].tpc;
            pipe_pc    = tbl[i].ppc;
            pipe_empty = tbl[i].empty;
            rfi        = tbl[i].rfi;
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].e_stall, tbl[i].e_redir, tbl[i].e_rpc,
                    tbl[i].e_srr0, tbl[i].e_cause, tbl[i].e_ack, tbl[i].e_en, tbl[i].e_inh);
        end
        quiet_inputs();

        // Drain wait: request drops during DRAIN, stall holds until pipe empties
        irq_req    = 4'b0010;
        pipe_empty = 1'b0;
        pipe_pc    = 30'h500;
        tick();
        chk("drain.stall0", 64'(pipe_stall), 64'd1);
        chk("drain.en0",    64'(en_int),     64'd0);
        irq_req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            pipe_pc = 30'h501 + 30'(i);
            tick();
            chk($sformatf("drain.stall%0d", i + 1), 64'({pipe_stall, redirect}), 64'b10);
        end
        pipe_empty = 1'b1;
        pipe_pc    = 30'h1234;
        tick();
        chk_all("drain.enter", 1'b1, 1'b1, 30'h50, 30'h1234, 4'd2, 4'b0010, 1'b0, 1'b0);
        pipe_pc = 30'h9999;
        tick();
        chk("drain.srr0_hold", 64'(srr0), 64'h1234);
        rfi = 1'b1;
        tick();
        chk("drain.ret_pc", 64'({redirect, redirect_pc}), {33'd0, 1'b1, 30'h1234});
        rfi = 1'b0;
        tick();
        chk("drain.idle_en", 64'(en_int), 64'd1);

        // Masking: global disable, then per-line mask
        ee      = 1'b0;
        irq_req = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                ee       = 1'b1;
                irq_mask = 4'h0;
            end
            tick();
            chk($sformatf("mask%0d", i), 64'({en_int, pipe_stall, redirect}), 64'b100);
        end
        irq_req  = 4'h0;
        irq_mask = 4'hF;

        // No nesting: requests and traps ignored in HANDLER; stray rfi in IDLE
        trap_hit = 1'b1;
        trap_pc  = 30'h700;
        tick();
        trap_hit = 1'b0;
        tick();
        tick();
        chk("nest.in_handler", 64'(in_handler), 64'd1);
        irq_req  = 4'b0010;
        trap_hit = 1'b1;
        trap_pc  = 30'h777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("nest%0d", i), 1'b0, 1'b0, 30'h0, 30'h700, 4'd0, 4'h0, 1'b0, 1'b1);
        end
        irq_req  = 4'h0;
        trap_hit = 1'b0;
        rfi      = 1'b1;
        tick();
        chk("nest.ret_pc", 64'(redirect_pc), 64'h700);
        rfi = 1'b0;
        tick();
        rfi = 1'b1;
        tick();
        chk("stray_rfi", 64'({redirect, en_int, pipe_stall}), 64'b010);
        rfi = 1'b0;
        tick();
        chk("stray_rfi.after", 64'({redirect, en_int}), 64'b01);

        // Reset in the middle of DRAIN
        irq_req    = 4'b0001;
        pipe_empty = 1'b0;
        tick();
        chk("rst.in_drain", 64'(pipe_stall), 64'd1);
        irq_req = 4'h0;
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst.immediate", 1'b0, 1'b0, 30'h0, 30'h0, 4'd0, 4'h0, 1'b1, 1'b0);
        pipe_empty = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("rst.after%0d", i), 1'b0, 1'b0, 30'h0, 30'h0, 4'd0, 4'h0, 1'b1, 1'b0);
        end

        // Randomized run against the reference model
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            irq_req    = 4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'hF : 4'h0);
            irq_mask   = 4'($urandom_range(0, 15));
            ee         = ($urandom_range(0, 4) != 0);
            trap_hit   = ($urandom_range(0, 7) == 0);
            trap_pc    = 30'($urandom);
            pipe_pc    = 30'($urandom);
            pipe_empty = ($urandom_range(0, 1) == 1);
            rfi        = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
                tick();
                reset = 1'b1;
            end else begin
                model_edge();
                tick();
            end
            model_check($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_sched.md
# int_sched

Interrupt/trap sequencer for the core. Arbitrates external interrupt lines and the program interrupt raised by the trap unit, then sequences the entry: pipeline stall, drain, SRR0 capture, vector redirect and handler residency. On `rfi` it sequences the return. It drives the `en_int` term of the trap control interface so a trap instruction cannot fire while an interrupt is being entered or handled.

## Interface
Parameters:
- `N_SRC`, 4: number of external interrupt lines (1..15).
- `PC_W`, 30: word-address PC width.
- `VEC_BASE`, 30'h40: word address of vector 0.
- `VEC_SHIFT`, 3: log2 of vector spacing in words.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `irq_req` in N_SRC: level-sensitive interrupt requests.
- `irq_mask` in N_SRC: per-line enable; 1 = enabled.
- `ee` in 1: global external-interrupt enable (MSR[EE]).
- `trap_hit` in 1: trap condition true this cycle (program interrupt).
- `trap_pc` in PC_W: address of the trapping instruction.
- `pipe_pc` in PC_W: address of the next instruction to commit.
- `pipe_empty` in 1: no instruction in flight past fetch.
- `rfi` in 1: single-cycle pulse, return-from-interrupt committed.
- `pipe_stall` out 1: hold fetch/issue.
- `redirect` out 1: single-cycle pulse, load `redirect_pc` into fetch.
- `redirect_pc` out PC_W: redirect target.
- `srr0` out PC_W: saved return address.
- `cause` out 4: 0 = program, 1+i = irq line i.
- `irq_ack` out N_SRC: one-hot single-cycle acknowledge.
- `en_int` out 1: trap enable term (trap fires only if `en_int & en_dec`).
- `in_handler` out 1: high in HANDLER state.

## Operation
States: IDLE, DRAIN, ENTER, HANDLER, RETURN.

- **Reset values:** IDLE; `pipe_stall=0`, `redirect=0`, `redirect_pc=0`, `srr0=0`, `cause=0`, `irq_ack=0`, `en_int=1`, `in_handler=0`.
- **IDLE:**
  - `pend = irq_req & irq_mask & {N_SRC{ee}}`.
  - If `trap_hit`: `cause<=0`, `srr0<=trap_pc`, go to DRAIN.
  - Else if `pend != 0`: `cause <=` 1 + index of the lowest set bit, go to DRAIN.
  - Trap wins over a simultaneous irq. The irq, being level-sensitive, is retaken after return.
- **DRAIN:**
  - `pipe_stall=1`, `en_int=0`.
  - When `pipe_empty`: for irq causes, `srr0<=pipe_pc`; go to ENTER.
  - Cause is latched; deassertion of `irq_req` during DRAIN does not cancel entry.
- **ENTER** (one cycle):
  - `redirect=1`, `redirect_pc = VEC_BASE + (cause << VEC_SHIFT)`, truncated to PC_W (wraps modulo 2^PC_W).
  - `irq_ack[cause-1]=1` for irq causes; all zero for program.
  - `pipe_stall=1`. Go to HANDLER.
- **HANDLER:**
  - `pipe_stall=0`, `en_int=0`, `in_handler=1`.
  - No nesting: `irq_req` and `trap_hit` are ignored.
  - On `rfi`, go to RETURN.
- **RETURN** (one cycle):
  - `redirect=1`, `redirect_pc=srr0`, `pipe_stall=1`, `en_int=0`. Go to IDLE.
- `en_int=1` only in IDLE. `trap_hit` outside IDLE is ignored.
- `rfi` outside HANDLER is ignored.
- Async reset in any state returns to IDLE with reset values. No ack or redirect is emitted.

## Timing
- `trap_hit` or pending irq at IDLE edge k:
  - DRAIN from k+1: `pipe_stall`=1 and `en_int`=0 visible in cycle k+1.
- `pipe_empty` seen in DRAIN at edge m: ENTER during cycle m+1 (`redirect`, `irq_ack` high), HANDLER from m+2.
- Minimum entry latency when `pipe_empty` is already high: request cycle → `redirect` 2 cycles later.
- `rfi` at HANDLER edge r: RETURN in cycle r+1, IDLE in r+2. A pending irq can be taken at edge r+2.
- All outputs are registered state decodes. `redirect_pc` is stable whenever `redirect`=1.

## Test plan
- **Irq entry and return:** reset, `irq_mask`=4'hF, `ee`=1, `pipe_empty`=1, `pipe_pc`=30'h100, pulse `irq_req[2]` → `redirect` 2 cycles later with `redirect_pc`=30'h58, `cause`=3, `irq_ack`=4'b0100, `srr0`=30'h100. Then `rfi` → `redirect_pc`=30'h100 next cycle, `en_int`=1 the cycle after.
- **Trap beats irq:** `trap_hit`, `trap_pc`=30'h200 and `irq_req[0]` in the same cycle → `cause`=0, `redirect_pc`=30'h40, `srr0`=30'h200, no `irq_ack`. After `rfi` with `irq_req[0]` still high → irq entered with `cause`=1, `redirect_pc`=30'h48.
- **Drain wait:** `pipe_empty`=0 for 5 cycles after the request → `pipe_stall` high for those 5 cycles plus ENTER. `srr0` equals the `pipe_pc` present on the `pipe_empty` cycle.
- **Masking:** `ee`=0 with `irq_req`=4'hF, or `irq_mask`=0 → stays in IDLE, `en_int`=1, no stall.
- **No nesting:** in HANDLER, assert `irq_req[1]` and `trap_hit` → no state change, `en_int`=0. A stray `rfi` in IDLE → no `redirect`.
- **Reset mid-DRAIN:** deassert `reset` during DRAIN → all outputs at reset values immediately. After release, no ack or redirect unless a new request arrives.
